// File: rtl/mem_access_stage.sv
// LEGv8 data-memory access stage: drives a req/ack memory port, aligns load data,
// builds store byte enables, and stalls the pipeline until the access finishes.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] MEMALUOut,
    input  logic [63:0] MEMWriteData,
    input  logic        MEMMemRead,
    input  logic        MEMMemWrite,
    input  logic [1:0]  MEMXferSize,
    output logic [63:0] MEMOut,
    output logic        MEMStall,
    output logic        memReq,
    output logic        memWe,
    output logic [63:0] memAddr,
    output logic [7:0]  memByteEn,
    output logic [63:0] memWData,
    input  logic [63:0] memRData,
    input  logic        memAck,
    output logic        memError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [63:0]   addr_q, addr_d;
    logic [2:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          we_q, we_d;
    logic [7:0]    be_q, be_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   load_q, load_d;
    logic          err_q, err_d;

    logic        op;
    logic        is_write;
    logic        misaligned;
    logic [7:0]  be_calc;
    logic [63:0] wdata_rep;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    assign op       = MEMMemRead | MEMMemWrite;
    assign is_write = MEMMemWrite & ~MEMMemRead;

    // Request decode: alignment, lane enables and lane-replicated store data.
    always_comb begin
        misaligned = 1'b0;
        be_calc    = 8'h00;
        wdata_rep  = 64'h0;
        case (MEMXferSize)
            2'b00: begin
                misaligned = 1'b0;
                be_calc    = 8'h01 << MEMALUOut[2:0];
                wdata_rep  = {8{MEMWriteData[7:0]}};
            end
            2'b01: begin
                misaligned = MEMALUOut[0];
                be_calc    = 8'h03 << MEMALUOut[2:0];
                wdata_rep  = {4{MEMWriteData[15:0]}};
            end
            2'b10: begin
                misaligned = |MEMALUOut[1:0];
                be_calc    = 8'h0F << MEMALUOut[2:0];
                wdata_rep  = {2{MEMWriteData[31:0]}};
            end
            default: begin
                misaligned = |MEMALUOut[2:0];
                be_calc    = 8'hFF;
                wdata_rep  = MEMWriteData;
            end
        endcase
    end

    // Load alignment uses the latched offset and size, since the port data arrives later.
    always_comb begin
        shifted  = memRData >> {off_q, 3'b000};
        load_ext = 64'h0;
        case (size_q)
            2'b00:   load_ext = {56'h0, shifted[7:0]};
            2'b01:   load_ext = {48'h0, shifted[15:0]};
            2'b10:   load_ext = {32'h0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (op) begin
                    if (misaligned) begin
                        err_d   = 1'b1;
                        load_d  = 64'h0;
                        state_d = DONE;
                    end else begin
                        addr_d  = {MEMALUOut[63:3], 3'b000};
                        off_d   = MEMALUOut[2:0];
                        size_d  = MEMXferSize;
                        we_d    = is_write;
                        be_d    = be_calc;
                        wdata_d = wdata_rep;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // An ack on the final allowed cycle still completes the access.
                if (memAck) begin
                    load_d  = we_q ? 64'h0 : load_ext;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    load_d  = 64'h0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= 64'h0;
            off_q   <= 3'd0;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
            be_q    <= 8'h00;
            wdata_q <= 64'h0;
            cnt_q   <= '0;
            load_q  <= 64'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    logic busy;
    assign busy = (state_q == BUSY);

    // Stall is also gated by reset so the pipeline is released the instant reset asserts.
    assign MEMStall  = reset & (((state_q == IDLE) & op) | busy);
    assign memReq    = busy;
    assign memWe     = busy & we_q;
    assign memAddr   = busy ? addr_q : 64'h0;
    assign memByteEn = busy ? be_q : 8'h00;
    assign memWData  = busy ? wdata_q : 64'h0;
    assign MEMOut    = (state_q == DONE) ? load_q : 64'h0;
    assign memError  = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written reset/timeout
// sequences, and randomized accesses checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] MEMALUOut;
    logic [63:0] MEMWriteData;
    logic        MEMMemRead;
    logic        MEMMemWrite;
    logic [1:0]  MEMXferSize;
    logic [63:0] MEMOut;
    logic        MEMStall;
    logic        memReq;
    logic        memWe;
    logic [63:0] memAddr;
    logic [7:0]  memByteEn;
    logic [63:0] memWData;
    logic [63:0] memRData;
    logic        memAck;
    logic        memError;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .MEMALUOut(MEMALUOut),
        .MEMWriteData(MEMWriteData),
        .MEMMemRead(MEMMemRead),
        .MEMMemWrite(MEMMemWrite),
        .MEMXferSize(MEMXferSize),
        .MEMOut(MEMOut),
        .MEMStall(MEMStall),
        .memReq(memReq),
        .memWe(memWe),
        .memAddr(memAddr),
        .memByteEn(memByteEn),
        .memWData(memWData),
        .memRData(memRData),
        .memAck(memAck),
        .memError(memError)
    );

    int checks = 0;
    int errors = 0;
    logic model_err = 1'b0;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  size;
        logic        rd;
        logic        wr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_out;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
        end
    endtask

    // Reference model: byte-wise view of the access rules.
    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit ref_misaligned(input logic [63:0] addr, input logic [1:0] size);
        return (int'(addr[2:0]) % nbytes(size)) != 0;
    endfunction

    function automatic logic [7:0] ref_be(input logic [63:0] addr, input logic [1:0] size);
        logic [7:0] be = 8'h00;
        for (int i = 0; i < nbytes(size); i++) be[int'(addr[2:0]) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] rdata);
        logic [63:0] r = 64'h0;
        for (int i = 0; i < nbytes(size); i++) r[8*i +: 8] = rdata[8*(int'(addr[2:0]) + i) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [1:0] size, input logic [63:0] d);
        logic [63:0] w = 64'h0;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = d[8*(j % nbytes(size)) +: 8];
        return w;
    endfunction

    task automatic applyStimulus(input string tag, input vec_t v);
        int  stall_cycles = 0;
        int  busy_cycles = 0;
        bit  saw_req = 1'b0;
        bit  finished = 1'b0;
        @(negedge clk);
        MEMALUOut    = v.addr;
        MEMXferSize  = v.size;
        MEMMemRead   = v.rd;
        MEMMemWrite  = v.wr;
        MEMWriteData = v.wdata;
        memAck       = 1'b0;
        memRData     = ~v.rdata;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (!MEMStall) begin
                finished = 1'b1;
                break;
            end
            stall_cycles++;
            if (memReq) begin
                if (!saw_req) begin
                    checkOutput({tag, " memAddr"}, memAddr, {v.addr[63:3], 3'b000});
                    checkOutput({tag, " memByteEn"}, 64'(memByteEn), 64'(v.exp_be));
                    checkOutput({tag, " memWe"}, 64'(memWe), 64'(v.wr & ~v.rd));
                    if (v.wr && !v.rd) checkOutput({tag, " memWData"}, memWData, v.exp_wdata);
                end
                saw_req = 1'b1;
                if (busy_cycles == v.waits) begin
                    memAck   = 1'b1;
                    memRData = v.rdata;
                end
                busy_cycles++;
            end
            @(negedge clk);
            memAck   = 1'b0;
            memRData = ~v.rdata;
        end
        if (!finished) begin
            checkOutput({tag, " stall bound"}, 64'(0), 64'(1));
        end else begin
            checkOutput({tag, " stall cycles"}, 64'(stall_cycles), 64'(v.exp_stall));
            checkOutput({tag, " memReq seen"}, 64'(saw_req), 64'(v.exp_stall > 1));
            checkOutput({tag, " MEMOut"}, MEMOut, v.exp_out);
            checkOutput({tag, " memError"}, 64'(memError), 64'(v.exp_err));
        end
    endtask

    // Fill in model-derived expectations for an arbitrary access.
    function automatic vec_t model_vec(input logic [63:0] addr, input logic [1:0] size, input logic rd,
                                       input logic wr, input logic [63:0] wdata, input logic [63:0] rdata,
                                       input int waits);
        vec_t v;
        bit op  = rd | wr;
        bit mis = ref_misaligned(addr, size);
        v.addr = addr; v.size = size; v.rd = rd; v.wr = wr;
        v.wdata = wdata; v.rdata = rdata; v.waits = waits;
        v.exp_be    = ref_be(addr, mis ? 2'b00 : size);
        v.exp_wdata = ref_wdata(size, wdata);
        v.exp_out   = 64'h0;
        if (!op) v.exp_stall = 0;
        else if (mis) v.exp_stall = 1;
        else if (waits < TIMEOUT) v.exp_stall = waits + 2;
        else v.exp_stall = TIMEOUT + 1;
        if (op && !mis && waits < TIMEOUT && rd) v.exp_out = ref_load(addr, size, rdata);
        if (op && (mis || waits >= TIMEOUT)) model_err = 1'b1;
        v.exp_err = model_err;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = '{64'h100, 2'b11, 1'b1, 1'b0, 64'h0, 64'h1122334455667788, 0, 8'hFF, 64'h0, 64'h1122334455667788, 2, 1'b0};
        vecs[1]  = '{64'h105, 2'b00, 1'b1, 1'b0, 64'h0, 64'hAABBCCDDEEFF0011, 3, 8'h20, 64'h0, 64'h00000000000000CC, 5, 1'b0};
        vecs[2]  = '{64'h10A, 2'b01, 1'b0, 1'b1, 64'h123456789ABCBEEF, 64'h0, 1, 8'h0C, 64'hBEEFBEEFBEEFBEEF, 64'h0, 3, 1'b0};
        vecs[3]  = '{64'h104, 2'b10, 1'b1, 1'b0, 64'h0, 64'h0123456789ABCDEF, 2, 8'hF0, 64'h0, 64'h0000000001234567, 4, 1'b0};
        vecs[4]  = '{64'h108, 2'b11, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hCAFEF00D12345678, 0, 8'hFF, 64'h0, 64'hCAFEF00D12345678, 2, 1'b0};
        vecs[5]  = '{64'h333, 2'b00, 1'b0, 1'b0, 64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0, 1'b0};
        vecs[6]  = '{64'h0F7, 2'b00, 1'b0, 1'b1, 64'h00000000000000A5, 64'h0, 0, 8'h80, 64'hA5A5A5A5A5A5A5A5, 64'h0, 2, 1'b0};
        vecs[7]  = '{64'h308, 2'b11, 1'b1, 1'b0, 64'h0, 64'h0F0E0D0C0B0A0908, 3, 8'hFF, 64'h0, 64'h0F0E0D0C0B0A0908, 5, 1'b0};
        vecs[8]  = '{64'h106, 2'b01, 1'b1, 1'b0, 64'h0, 64'hAABBCCDDEEFF0011, 0, 8'hC0, 64'h0, 64'h000000000000AABB, 2, 1'b0};
        vecs[9]  = '{64'h10C, 2'b10, 1'b0, 1'b1, 64'h55555555DEADBEEF, 64'h0, 2, 8'hF0, 64'hDEADBEEFDEADBEEF, 64'h0, 4, 1'b0};
        vecs[10] = '{64'h107, 2'b01, 1'b1, 1'b0, 64'h0, 64'hAABBCCDDEEFF0011, 0, 8'h00, 64'h0, 64'h0, 1, 1'b1};
        vecs[11] = '{64'h102, 2'b10, 1'b1, 1'b0, 64'h0, 64'h0123456789ABCDEF, 0, 8'h00, 64'h0, 64'h0, 1, 1'b1};
        vecs[12] = '{64'h338, 2'b00, 1'b0, 1'b0, 64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0, 1'b1};
        vecs[13] = '{64'h110, 2'b11, 1'b1, 1'b0, 64'h0, 64'h8877665544332211, 1, 8'hFF, 64'h0, 64'h8877665544332211, 3, 1'b1};

        reset = 1'b0;
        MEMALUOut = 64'h0; MEMWriteData = 64'h0; MEMMemRead = 1'b0; MEMMemWrite = 1'b0;
        MEMXferSize = 2'b00; memRData = 64'h0; memAck = 1'b0;
        #12;
        checkOutput("reset memReq", 64'(memReq), 64'(0));
        checkOutput("reset memWe", 64'(memWe), 64'(0));
        checkOutput("reset MEMStall", 64'(MEMStall), 64'(0));
        checkOutput("reset memError", 64'(memError), 64'(0));
        checkOutput("reset memAddr", memAddr, 64'h0);
        checkOutput("reset memByteEn", 64'(memByteEn), 64'(0));
        checkOutput("reset memWData", memWData, 64'h0);
        checkOutput("reset MEMOut", MEMOut, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Reset pulled during BUSY abandons the request; any ack during reset is ignored.
        @(negedge clk);
        MEMALUOut = 64'h200; MEMXferSize = 2'b11; MEMMemRead = 1'b1; MEMMemWrite = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midreset busy memReq", 64'(memReq), 64'(1));
        reset = 1'b0;
        #1;
        checkOutput("midreset memReq", 64'(memReq), 64'(0));
        checkOutput("midreset MEMStall", 64'(MEMStall), 64'(0));
        checkOutput("midreset memError", 64'(memError), 64'(0));
        memAck = 1'b1;
        memRData = 64'hDEADDEADDEADDEAD;
        @(negedge clk);
        memAck = 1'b0;
        MEMMemRead = 1'b0;
        reset = 1'b1;
        model_err = 1'b0;
        #1;
        checkOutput("postreset MEMStall", 64'(MEMStall), 64'(0));
        checkOutput("postreset MEMOut", MEMOut, 64'h0);
        v = model_vec(64'h200, 2'b11, 1'b1, 1'b0, 64'h0, 64'h0123456789ABCDEF, 0);
        applyStimulus("postreset load", v);

        // Timeout, then a late ack while idle must be ignored.
        v = model_vec(64'h300, 2'b11, 1'b1, 1'b0, 64'h0, 64'h1111111111111111, 99);
        applyStimulus("timeout", v);
        @(negedge clk);
        MEMMemRead = 1'b0; MEMMemWrite = 1'b0;
        memAck = 1'b1;
        memRData = 64'hFEEDFACEFEEDFACE;
        #1;
        checkOutput("late ack MEMStall", 64'(MEMStall), 64'(0));
        checkOutput("late ack memReq", 64'(memReq), 64'(0));
        @(negedge clk);
        memAck = 1'b0;
        #1;
        checkOutput("late ack MEMOut", MEMOut, 64'h0);
        checkOutput("late ack memError", 64'(memError), 64'(1));
        v = model_vec(64'h408, 2'b10, 1'b1, 1'b0, 64'h0, 64'h7766554433221100, 2);
        applyStimulus("after late ack", v);

        for (int n = 0; n < 150; n++) begin
            logic [63:0] addr;
            logic [1:0]  size;
            logic        rd, wr;
            int          kind;
            addr = {$urandom, $urandom};
            size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nbytes(size) - 1);
            kind = $urandom_range(0, 9);
            rd = (kind >= 3);
            wr = (kind == 1) || (kind == 2) || (kind == 3);
            v = model_vec(addr, size, rd, wr, {$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(0, TIMEOUT + 1));
            applyStimulus($sformatf("rnd%0d", n), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
